alu_arbiter: RTL and testbench

- Shares the single combinational `alu` instance between NREQ requesters.
- Round-robin arbitration, with a valid/ready request handshake per requester and a response channel that supports backpressure.
- Operands and results are registered, so the ALU sees stable inputs for a full cycle.
- Sits in pd0 between the requester probes/agents and the `alu` instance. It drives the ALU's sel/op1/op2 and consumes its res/zero/neg.

---
 rtl/constants_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/constants_pkg.sv
// Shared encodings for the pd0 ALU and the arbiter that fronts it.
package constants_pkg;

    // Operation encodings understood by the alu sel_i input.
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_o
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = idx;
            end
        end
    end

    assign any_o = |req;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational alu among NREQ requesters.
// Optional: define ALU_ARB_B2B_EN to accept the next request in the response-handshake cycle.
module alu_arbiter
    import constants_pkg::*;
#(
    parameter  int DWIDTH = 32,
    parameter  int NREQ   = 4,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [2*NREQ-1:0]      req_sel_i,
    input  logic [DWIDTH*NREQ-1:0] req_op1_i,
    input  logic [DWIDTH*NREQ-1:0] req_op2_i,
    output logic [NREQ-1:0]        req_ready_o,
    output logic [1:0]             alu_sel_o,
    output logic [DWIDTH-1:0]      alu_op1_o,
    output logic [DWIDTH-1:0]      alu_op2_o,
    input  logic [DWIDTH-1:0]      alu_res_i,
    input  logic                   alu_zero_i,
    input  logic                   alu_neg_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [IDW-1:0]         rsp_id_o,
    output logic [DWIDTH-1:0]      rsp_res_o,
    output logic                   rsp_zero_o,
    output logic                   rsp_neg_o
);

    arb_state_t        state;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    grant_id;
    alu_sel_t          op_sel_q;
    logic [DWIDTH-1:0] op1_q;
    logic [DWIDTH-1:0] op2_q;
    logic [DWIDTH-1:0] res_q;
    logic              zero_q;
    logic              neg_q;

    logic [NREQ-1:0]   arb_grant;
    logic [IDW-1:0]    arb_idx;
    logic              arb_any;
    logic              accept;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req       (req_valid_i),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_o     (arb_any)
    );

    // Gated by reset as well, so no accept strobe is visible while reset is held.
    always_comb begin
        accept = 1'b0;
        if (reset) begin
            if (state == IDLE) begin
                accept = arb_any;
            end
`ifdef ALU_ARB_B2B_EN
            if (state == RESP && rsp_ready_i) begin
                accept = arb_any;
            end
`else
            // Responses always drain back through IDLE before the next grant.
`endif
        end
    end

    assign req_ready_o = accept ? arb_grant : '0;

    // NOTE: datapath regs are reset too, because the alu and response outputs must read 0 after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            op_sel_q <= ALU_ADD;
            op1_q    <= '0;
            op2_q    <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_sel_q <= alu_sel_t'(req_sel_i[2*int'(arb_idx) +: 2]);
                op1_q    <= req_op1_i[DWIDTH*int'(arb_idx) +: DWIDTH];
                op2_q    <= req_op2_i[DWIDTH*int'(arb_idx) +: DWIDTH];
                grant_id <= arb_idx;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_q  <= alu_res_i;
                    zero_q <= alu_zero_i;
                    neg_q  <= alu_neg_i;
                    rr_ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
                    state  <= RESP;
                end
                RESP: begin
                    // accept is only ever set here in the back-to-back build.
                    if (rsp_ready_i) begin
                        state <= accept ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alu_sel_o   = op_sel_q;
    assign alu_op1_o   = op1_q;
    assign alu_op2_o   = op2_q;
    assign rsp_valid_o = (state == RESP);
    assign rsp_id_o    = grant_id;
    assign rsp_res_o   = res_q;
    assign rsp_zero_o  = zero_q;
    assign rsp_neg_o   = neg_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural stand-in for the shared alu.
module tb_alu_arbiter;
    import constants_pkg::*;

    localparam int DW  = 32;
    localparam int NR  = 4;
    localparam int IDW = 2;
`ifdef ALU_ARB_B2B_EN
    localparam int PERIOD = 2;
`else
    localparam int PERIOD = 3;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [2*NR-1:0]   req_sel;
    logic [DW*NR-1:0]  req_op1;
    logic [DW*NR-1:0]  req_op2;
    logic [NR-1:0]     req_ready_o;
    logic [1:0]        alu_sel_o;
    logic [DW-1:0]     alu_op1_o;
    logic [DW-1:0]     alu_op2_o;
    logic [DW-1:0]     alu_res;
    logic              alu_zero;
    logic              alu_neg;
    logic              rsp_valid_o;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id_o;
    logic [DW-1:0]     rsp_res_o;
    logic              rsp_zero_o;
    logic              rsp_neg_o;

    int vectors     = 0;
    int miscompares = 0;

    alu_arbiter #(
        .DWIDTH (DW),
        .NREQ   (NR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_sel_i   (req_sel),
        .req_op1_i   (req_op1),
        .req_op2_i   (req_op2),
        .req_ready_o (req_ready_o),
        .alu_sel_o   (alu_sel_o),
        .alu_op1_o   (alu_op1_o),
        .alu_op2_o   (alu_op2_o),
        .alu_res_i   (alu_res),
        .alu_zero_i  (alu_zero),
        .alu_neg_i   (alu_neg),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id_o),
        .rsp_res_o   (rsp_res_o),
        .rsp_zero_o  (rsp_zero_o),
        .rsp_neg_o   (rsp_neg_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_res = '0;
        case (alu_sel_o)
            ALU_ADD: alu_res = alu_op1_o + alu_op2_o;
            ALU_SUB: alu_res = alu_op1_o - alu_op2_o;
            ALU_AND: alu_res = alu_op1_o & alu_op2_o;
            ALU_OR:  alu_res = alu_op1_o | alu_op2_o;
            default: alu_res = '0;
        endcase
    end
    assign alu_zero = (alu_res == '0);
    assign alu_neg  = alu_res[DW-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int idx, input alu_sel_t sel, input logic [31:0] a, input logic [31:0] b);
        req_sel[2*idx +: 2]   = sel;
        req_op1[DW*idx +: DW] = a;
        req_op2[DW*idx +: DW] = b;
        req_valid[idx]        = 1'b1;
    endtask

    task automatic do_single(input int idx, input alu_sel_t sel, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input logic exp_zero, input logic exp_neg);
        @(negedge clk);
        set_req(idx, sel, a, b);
        #1;
        check("single_ready", req_ready_o, 32'd1 << idx);
        @(negedge clk);
        req_valid[idx] = 1'b0;
        #1;
        check("exec_valid", rsp_valid_o, 0);
        check("exec_sel", alu_sel_o, sel);
        check("exec_op1", alu_op1_o, a);
        check("exec_op2", alu_op2_o, b);
        @(negedge clk);
        #1;
        check("rsp_valid", rsp_valid_o, 1);
        check("rsp_id", rsp_id_o, idx);
        check("rsp_res", rsp_res_o, exp_res);
        check("rsp_zero", rsp_zero_o, exp_zero);
        check("rsp_neg", rsp_neg_o, exp_neg);
    endtask

    // Waits (bounded) for requester idx to be accepted, then for its response.
    task automatic drain(input int idx, input logic [31:0] exp_res);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            if (req_ready_o == 4'(1 << idx)) found = 1'b1;
            else begin @(negedge clk); #1; end
        end
        check("drain_acc", found, 1);
        @(negedge clk);
        req_valid[idx] = 1'b0;
        #1;
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            if (rsp_valid_o) found = 1'b1;
            else begin @(negedge clk); #1; end
        end
        check("drain_rsp", found, 1);
        check("drain_id", rsp_id_o, idx);
        check("drain_res", rsp_res_o, exp_res);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          order[5];
        logic [31:0] rr_res[4];
        order  = '{0, 1, 2, 3, 0};
        rr_res = '{32'd1, 32'd17, 32'd33, 32'd49};

        reset     = 1'b0;
        req_valid = '0;
        req_sel   = '0;
        req_op1   = '0;
        req_op2   = '0;
        rsp_ready = 1'b1;
        #12;
        check("rst_valid", rsp_valid_o, 0);
        check("rst_ready", req_ready_o, 0);
        check("rst_sel", alu_sel_o, 0);
        check("rst_op1", alu_op1_o, 0);
        check("rst_op2", alu_op2_o, 0);
        check("rst_id", rsp_id_o, 0);
        check("rst_res", rsp_res_o, 0);
        check("rst_flags", {rsp_zero_o, rsp_neg_o}, 0);
        @(negedge clk);
        reset = 1'b1;

        // Round robin: all four continuously valid, requester k adds k*16 + 1.
        @(negedge clk);
        for (int k = 0; k < NR; k++) set_req(k, ALU_ADD, 32'(k * 16), 32'd1);
        #1;
        for (int n = 0; n < 5; n++) begin
            if (n > 0 && PERIOD == 3) begin @(negedge clk); #1; end
            check("rr_grant", req_ready_o, 32'd1 << order[n]);
            @(negedge clk); #1;
            check("rr_exec", rsp_valid_o, 0);
            @(negedge clk); #1;
            check("rr_valid", rsp_valid_o, 1);
            check("rr_id", rsp_id_o, order[n]);
            check("rr_res", rsp_res_o, rr_res[order[n]]);
        end
        req_valid = '0;

        // Single requester and flag cases.
        do_single(0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        do_single(2, ALU_SUB, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);
        do_single(2, ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b1);

        // Reset during EXEC: rr_ptr is 3 here, so the post-reset grant shows it returned to 0.
        @(negedge clk);
        set_req(1, ALU_SUB, 32'd10, 32'd4);
        #1;
        check("mid_ready", req_ready_o, 4'b0010);
        @(negedge clk);
        set_req(3, ALU_OR, 32'd1, 32'd2);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid_o, 0);
        check("mid_rst_ready", req_ready_o, 0);
        check("mid_rst_op1", alu_op1_o, 0);
        check("mid_rst_sel", alu_sel_o, 0);
        check("mid_rst_res", rsp_res_o, 0);
        check("mid_rst_neg", rsp_neg_o, 0);
        check("mid_rst_id", rsp_id_o, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rearb", req_ready_o, 4'b0010);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1;
        check("mid_exec", rsp_valid_o, 0);
        @(negedge clk); #1;
        check("mid_rsp_valid", rsp_valid_o, 1);
        check("mid_rsp_id", rsp_id_o, 1);
        check("mid_rsp_res", rsp_res_o, 32'd6);
        drain(3, 32'd3);

        // Backpressure: response held for 5 cycles while requester 3 waits.
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(1, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
        #1;
        check("bp_accept", req_ready_o, 4'b0010);
        @(negedge clk);
        req_valid[1] = 1'b0;
        set_req(3, ALU_OR, 32'h10, 32'h01);
        #1;
        check("bp_exec", rsp_valid_o, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            check("bp_valid", rsp_valid_o, 1);
            check("bp_res", rsp_res_o, 32'h0000_F000);
            check("bp_id", rsp_id_o, 1);
            check("bp_ready", req_ready_o, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        check("bp_last", rsp_valid_o, 1);
        check("bp_last_res", rsp_res_o, 32'h0000_F000);
        drain(3, 32'h11);

`ifdef ALU_ARB_B2B_EN
        // Back-to-back: second accept coincides with the first response handshake.
        @(negedge clk);
        set_req(1, ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        set_req(3, ALU_SUB, 32'd9, 32'd9);
        #1;
        check("b2b_first", req_ready_o, 4'b0010);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1;
        check("b2b_exec1", rsp_valid_o, 0);
        @(negedge clk); #1;
        check("b2b_rsp1", rsp_valid_o, 1);
        check("b2b_id1", rsp_id_o, 1);
        check("b2b_res1", rsp_res_o, 32'h8000_0000);
        check("b2b_neg1", rsp_neg_o, 1);
        check("b2b_second", req_ready_o, 4'b1000);
        @(negedge clk);
        req_valid[3] = 1'b0;
        #1;
        check("b2b_exec2", rsp_valid_o, 0);
        @(negedge clk); #1;
        check("b2b_rsp2", rsp_valid_o, 1);
        check("b2b_id2", rsp_id_o, 3);
        check("b2b_zero2", rsp_zero_o, 1);
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
